// File: rtl/gpio_irq_up5k_if.sv
// gpio_irq_up5k_if: zero-wait CPU bus shared with the GPIO block.
interface gpio_irq_up5k_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );
  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/gpio_irq_up5k.sv
// gpio_irq_up5k: pad input sync, per-pin edge detect, W1C pending and level irq.
// Define GPIO_IRQ_DEBOUNCE_EN to add tick-sampled 3-deep debounce ahead of edge detect.
module gpio_irq_up5k #(
  parameter logic [7:0] RESET_LEVEL  = 8'hFF,
  parameter int         DEBOUNCE_DIV = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      pins_in,
  gpio_irq_up5k_if.slave  bus,
  output logic            irq_out
);
  logic [7:0]  sync1, sync2, level, prev, rise_en, fall_en, pending, mask, set, clr;
  logic [2:0]  addr;
  logic        wr;
  logic [31:0] rd, reg5;
  logic        unused_ok;
  assign addr      = bus.address_in[4:2];
  assign wr        = bus.sel_in & bus.write_mask_in[0];
  assign set       = (level & ~prev & rise_en) | (~level & prev & fall_en);
  assign clr       = (wr && addr == 3'd3) ? bus.write_value_in[7:0] : 8'h00;
  assign irq_out   = |(pending & mask);
  assign bus.ready_out = bus.sel_in;
  assign unused_ok = ^{bus.read_in, bus.address_in[31:5], bus.address_in[1:0],
                       bus.write_mask_in[3:1], bus.write_value_in[31:8]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1   <= RESET_LEVEL;
      sync2   <= RESET_LEVEL;
      prev    <= RESET_LEVEL;
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      sync1   <= pins_in;
      sync2   <= sync1;
      prev    <= level;
      pending <= (pending & ~clr) | set;
      if (wr && addr == 3'd1) rise_en <= bus.write_value_in[7:0];
      if (wr && addr == 3'd2) fall_en <= bus.write_value_in[7:0];
      if (wr && addr == 3'd4) mask    <= bus.write_value_in[7:0];
    end
`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [15:0] cnt;
  logic        tick;
  logic [7:0]  h0, h1, h2;
  assign tick = cnt == 16'(DEBOUNCE_DIV - 1);
  assign reg5 = 32'(DEBOUNCE_DIV);
  // level follows only a unanimous history: all-ones sets, all-zeros clears
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      h0    <= RESET_LEVEL;
      h1    <= RESET_LEVEL;
      h2    <= RESET_LEVEL;
      level <= RESET_LEVEL;
    end else begin
      cnt   <= tick ? 16'd0 : cnt + 16'd1;
      if (tick) begin
        h0 <= sync2;
        h1 <= h0;
        h2 <= h1;
      end
      level <= (h0 & h1 & h2) | (level & (h0 | h1 | h2));
    end
`else
  assign level = sync2;
  assign reg5  = '0;
`endif
  assign rd = addr == 3'd0 ? {24'b0, level}   :
              addr == 3'd1 ? {24'b0, rise_en} :
              addr == 3'd2 ? {24'b0, fall_en} :
              addr == 3'd3 ? {24'b0, pending} :
              addr == 3'd4 ? {24'b0, mask}    :
              addr == 3'd5 ? reg5             : '0;
  assign bus.read_value_out = bus.sel_in ? rd : '0;
endmodule

// File: tb/tb_gpio_irq_up5k.sv
// tb_gpio_irq_up5k: directed vectors with hand-computed expectations.
module tb_gpio_irq_up5k;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1000;
`endif
  logic       clk = 0;
  logic       reset = 0;
  logic [7:0] pins = 8'hFF;
  logic       irq;
  int         errs = 0, checks = 0;
  gpio_irq_up5k_if bus();
  gpio_irq_up5k #(.RESET_LEVEL(8'hFF), .DEBOUNCE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .pins_in(pins), .bus(bus), .irq_out(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    bus.sel_in = 1; bus.address_in = {27'b0, a, 2'b0};
    bus.write_mask_in = 4'b0001; bus.write_value_in = {24'b0, v};
    cyc(1);
    bus.sel_in = 0; bus.write_mask_in = 0;
  endtask
  task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.sel_in = 1; bus.read_in = 1; bus.address_in = {27'b0, a, 2'b0};
    #1;
    chk(tag, bus.read_value_out, exp);
    bus.sel_in = 0; bus.read_in = 0;
    #1;
  endtask
  initial begin
    bus.sel_in = 0; bus.read_in = 0; bus.address_in = 0;
    bus.write_mask_in = 0; bus.write_value_in = 0;
    cyc(3);
    reset = 1;
    wr(3'd1, 8'hFF); wr(3'd2, 8'hFF); wr(3'd4, 8'hFF);
    cyc(4);
    chk("t1_irq", {31'b0, irq}, 0);
    rchk("t1_pending", 3'd3, 0);
    rchk("t1_level", 3'd0, 32'h0000_00FF);
    rchk("t1_rise_en", 3'd1, 32'h0000_00FF);
    rchk("reg5", 3'd5, (DIV == 4) ? 32'd4 : 32'd0);
`ifdef GPIO_IRQ_DEBOUNCE_EN
    wr(3'd1, 8'h00); wr(3'd2, 8'h08); wr(3'd4, 8'h08);
    pins = 8'hF7; cyc(8);
    pins = 8'hFF; cyc(30);
    rchk("t6_glitch_pending", 3'd3, 0);
    chk("t6_glitch_irq", {31'b0, irq}, 0);
    pins = 8'hF7; cyc(30);
    rchk("t6_pending", 3'd3, 32'h08);
    rchk("t6_level", 3'd0, 32'hF7);
    chk("t6_irq", {31'b0, irq}, 1);
`else
    wr(3'd1, 8'h00); wr(3'd2, 8'h00);
    pins = 8'hFE; cyc(4);
    wr(3'd1, 8'h01); wr(3'd4, 8'h01);
    rchk("t2_pre_pending", 3'd3, 0);
    pins = 8'hFF;
    cyc(2);
    chk("t2_k1_irq", {31'b0, irq}, 0);
    rchk("t2_k1_pending", 3'd3, 0);
    rchk("t2_k1_level", 3'd0, 32'hFF);
    cyc(1);
    chk("t2_k2_irq", {31'b0, irq}, 1);
    rchk("t2_k2_pending", 3'd3, 32'h01);
    wr(3'd3, 8'h01);
    chk("t2_clr_irq", {31'b0, irq}, 0);
    rchk("t2_clr_pending", 3'd3, 0);
    wr(3'd2, 8'h80); wr(3'd4, 8'h00);
    pins = 8'h7F; cyc(3);
    rchk("t3_pending", 3'd3, 32'h80);
    chk("t3_masked_irq", {31'b0, irq}, 0);
    wr(3'd4, 8'h80);
    chk("t3_unmask_irq", {31'b0, irq}, 1);
    wr(3'd3, 8'h80);
    chk("t3_clr_irq", {31'b0, irq}, 0);
    wr(3'd1, 8'h04);
    pins = 8'h7B; cyc(3);
    rchk("t4_fall_ignored", 3'd3, 0);
    pins = 8'h7F; cyc(2);
    wr(3'd3, 8'h04);
    rchk("t4_set_wins", 3'd3, 32'h04);
    wr(3'd3, 8'h04);
    rchk("t4_clear", 3'd3, 0);
    bus.sel_in = 1; bus.address_in = 32'h10;
    bus.write_mask_in = 4'b0010; bus.write_value_in = 32'hFFFF;
    cyc(1);
    chk("t5_ready_sel", {31'b0, bus.ready_out}, 1);
    bus.sel_in = 0; bus.write_mask_in = 0;
    #1;
    chk("t5_ready_idle", {31'b0, bus.ready_out}, 0);
    chk("t5_unsel_read", bus.read_value_out, 0);
    rchk("t5_mask_kept", 3'd4, 32'h80);
    rchk("t5_addr7", 3'd7, 0);
    pins = 8'hFF; cyc(3);
    pins = 8'h7F; cyc(3);
    rchk("t5_pending", 3'd3, 32'h80);
    chk("t5_irq_before", {31'b0, irq}, 1);
    #1 reset = 0;
    #1;
    chk("t5_async_irq", {31'b0, irq}, 0);
    rchk("t5_rst_pending", 3'd3, 0);
    rchk("t5_rst_level", 3'd0, 32'hFF);
    rchk("t5_rst_mask", 3'd4, 0);
    cyc(1);
    reset = 1;
`endif
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gpio_irq_up5k.md
Name: gpio_irq_up5k

Overview:
- Input-conditioning and interrupt stage directly downstream of the GPIO pad block; consumes the 8-bit raw pad input (SB_IO D_IN_0 vector).
- Synchronises the input, detects per-pin rising/falling edges, latches pending bits and drives one level interrupt to the CPU.
- Memory-mapped on the same CPU bus as the GPIO block, same handshake.

Parameters:
- RESET_LEVEL, 8'hFF, reset value of synchroniser/level/previous-level registers; matches the pad pull-ups so no false edge after reset.
- DEBOUNCE_DIV, 1000, sample-tick period in clk cycles (only used with DEBOUNCE_EN); range 2..65535.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- pins_in  input  8  raw pad inputs, asynchronous to clk.
- address_in  input  32  bus address; decode on [4:2].
- sel_in  input  1  block select.
- read_in  input  1  read strobe (decode does not depend on it).
- read_value_out  output  32  read data.
- write_mask_in  input  4  byte enables; only bit 0 is honoured.
- write_value_in  input  32  write data; only [7:0] is used.
- ready_out  output  1  equals sel_in (zero-wait).
- irq_out  output  1  level interrupt, high while any (pending & mask) bit is set.

Behaviour:
- Register map, address_in[4:2]:
  - 0 LEVEL (RO): conditioned input level.
  - 1 RISE_EN (RW).
  - 2 FALL_EN (RW).
  - 3 PENDING (R, write-1-to-clear).
  - 4 MASK (RW).
  - 5..7: read 0, writes ignored.
- Read data: read_value_out = {24'b0, reg} combinationally while sel_in=1, else 0.
- Write: on posedge clk when sel_in=1 and write_mask_in[0]=1; other byte lanes ignored.
- Synchroniser: two flops per pin (sync1, sync2). Without debounce, level = sync2.
- Edge detect:
  - prev <= level every cycle.
  - rise = level & ~prev; fall = ~level & prev.
  - set = (rise & RISE_EN) | (fall & FALL_EN).
- Pending update: pending <= (pending & ~clr) | set, where clr = write_value_in[7:0] on a PENDING write, else 0. A simultaneous set and clear on the same bit leaves the bit set (set wins).
- Pending latching is independent of MASK. MASK only gates irq_out.
- irq_out = |(pending & MASK), combinational from registers, no extra latency.
- Latency: pin stable before edge k gives sync1 at k, sync2/level at k+1, pending set at edge k+2, irq_out high after k+2. LEVEL readback reflects the pin after edge k+1.
- Changing RISE_EN/FALL_EN never creates or clears pending bits by itself.
- Pulses shorter than one clk may be missed. Each edge that survives synchronisation sets pending exactly once. Re-toggling while pending is already set is absorbed (no counting).
- Reset (async, any time):
  - sync1, sync2, level, prev <= RESET_LEVEL.
  - RISE_EN, FALL_EN, PENDING, MASK <= 0.
  - irq_out drops to 0 immediately; read_value_out is 0 unless selected.
  - The first post-reset edge is evaluated against RESET_LEVEL.

Optional Feature:
- Macro: GPIO_IRQ_DEBOUNCE_EN.
- Defined:
  - 16-bit tick counter counts 0..DEBOUNCE_DIV-1 and wraps. tick = (count == DEBOUNCE_DIV-1).
  - On each tick, each pin shifts sync2 into a 3-bit history.
  - level bit updates only when all 3 history bits agree and differ from the current level.
  - Edge/pending latency becomes 2 cycles after the qualifying tick.
  - Counter and history reset to 0 and RESET_LEVEL replicated respectively.
  - Register 5 reads {16'b0, DEBOUNCE_DIV} (RO).
- Not defined: no counter or history logic; level = sync2; register 5 reads 0.

Test Plan:
1. Reset release with pins_in=8'hFF, all enables set afterwards → PENDING=0, irq_out=0, LEVEL read=32'h000000FF.
2. RISE_EN=8'h01, MASK=8'h01; pins_in[0] 0→1 at edge k → PENDING=8'h01 and irq_out=1 after edge k+2; write PENDING 8'h01 → PENDING=0 and irq_out=0 next cycle.
3. FALL_EN=8'h80, MASK=0; pins_in[7] 1→0 → PENDING=8'h80, irq_out stays 0; write MASK=8'h80 → irq_out=1 same cycle after the write edge.
4. Clear-vs-set race: write PENDING=8'h04 on the same edge a new rising edge on pin 2 is detected → PENDING[2] stays 1.
5. Write with write_mask_in=4'b0010, value 32'hFFFF → MASK unchanged; read of address 7 → 0; reset asserted mid-pending → irq_out falls asynchronously.
6. (GPIO_IRQ_DEBOUNCE_EN, DEBOUNCE_DIV=4) 2-tick glitch on pin 3 → no pending; level held stable for 3 ticks → PENDING[3]=1.
